// File: rtl/ksa_add_seq.sv
// ksa_add_seq -- word-serial wide adder/subtractor built around one 32-bit
// Kogge-Stone adder.
//
// The operand is WORDS x 32 bits wide. One word is added per clock, least
// significant word first, and the carry is passed to the next word in a
// register. Subtraction is done as A + ~B + 1. B is inverted when it is
// captured, so the datapath itself always adds.
//
// Ports
//   clk, rst_n         clock; asynchronous active-low reset
//   in_valid/in_ready  request handshake (in_ready = 1 only in IDLE)
//   in_a, in_b         operands, word 0 = bits [31:0]
//   in_cin             carry-in, used only for add
//   in_op              0 = add (A+B+cin), 1 = subtract (A-B)
//   out_valid/out_ready result handshake (out_valid = 1 only in DONE)
//   out_sum, out_cout  result; for subtract, out_cout = 1 means no borrow
//   busy               operation in progress or result waiting (RUN/DONE)

// ksa_32bit -- 32-bit Kogge-Stone parallel-prefix adder with carry-in.
module ksa_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] p_s;
  logic [31:0] g_s;
  logic [31:0] gn_s;
  logic [31:0] pn_s;

  // Prefix tree: five doubling levels. The carry-in is folded into bit 0's
  // generate, so g_s[i] becomes the carry out of bit i.
  always_comb begin
    p_s     = a ^ b;
    g_s     = a & b;
    g_s[0]  = g_s[0] | (p_s[0] & cin);
    gn_s    = g_s;
    pn_s    = p_s;
    for (int lv = 0; lv < 5; lv++) begin
      for (int i = 0; i < 32; i++) begin
        if (i >= (1 << lv)) begin
          gn_s[i] = g_s[i] | (p_s[i] & g_s[i - (1 << lv)]);
          pn_s[i] = p_s[i] & p_s[i - (1 << lv)];
        end else begin
          gn_s[i] = g_s[i];
          pn_s[i] = p_s[i];
        end
      end
      g_s = gn_s;
      p_s = pn_s;
    end
  end

  // Sum bit i is the bit propagate XOR the carry into bit i.
  always_comb begin
    sum  = (a ^ b) ^ {g_s[30:0], cin};
    cout = g_s[31];
  end

endmodule

module ksa_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*WORDS-1:0]   in_a,
  input  logic [32*WORDS-1:0]   in_b,
  input  logic                  in_cin,
  input  logic                  in_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*WORDS-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  busy
);

  localparam int W  = 32 * WORDS;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;

  logic [31:0]     add_a_s;
  logic [31:0]     add_b_s;
  logic [31:0]     add_sum_s;
  logic            add_cout_s;

  // Select word k of both operand registers for the shared adder.
  always_comb begin
    add_a_s = a_q[{k_q, 5'd0} +: 32];
    add_b_s = b_q[{k_q, 5'd0} +: 32];
  end

  ksa_32bit u_ksa (
    .a    (add_a_s),
    .b    (add_b_s),
    .cin  (carry_q),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          // Subtract is A + ~B + 1: invert B here, seed the carry with 1.
          b_d     = in_op ? ~in_b : in_b;
          carry_d = in_op ? 1'b1 : in_cin;
          k_d     = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[{k_q, 5'd0} +: 32] = add_sum_s;
        carry_d                  = add_cout_s;
        if (k_q == K_LAST) begin
          cout_d  = add_cout_s;
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d     = k_q + KW'(1);
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Handshake and status outputs decode straight from the state register.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == RUN) || (state_q == DONE);
    out_sum   = sum_q;
    out_cout  = cout_q;
  end

endmodule

// File: tb/tb_ksa_add_seq.sv
module tb_ksa_add_seq;

  localparam int WORDS = 4;
  localparam int W     = 32 * WORDS;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_cin;
  logic          in_op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_cout;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W:0] sb_q[$];

  ksa_add_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: {cout,sum} of the full-width add or subtract.
  function automatic logic [W:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic op);
    if (op) return {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
    else    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  function automatic logic [W-1:0] rand_word_mix();
    logic [W-1:0] v;
    for (int i = 0; i < WORDS; i++) begin
      case ($urandom_range(0, 3))
        0:       v[i*32 +: 32] = 32'h0000_0000;
        1:       v[i*32 +: 32] = 32'hFFFF_FFFF;
        default: v[i*32 +: 32] = $urandom;
      endcase
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One directed operation: accept, check latency, hold in DONE, hand off.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic op, input logic [W:0] exp, input int hold);
    int cyc;
    logic [W:0] got;
    logic [W:0] held;
    in_a = a; in_b = b; in_cin = cin; in_op = op; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    chk({tag, "_in_ready_idle"}, {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
    sb_q.push_back(exp);
    step();
    // Scramble inputs after acceptance; must not affect the result.
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_cin = ~cin; in_op = ~op;
    chk({tag, "_busy_run"}, {{W{1'b0}}, busy, in_ready}, {{W{1'b0}}, 2'b10});
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      step();
      cyc++;
    end
    chk({tag, "_latency"}, (W+1)'(cyc), (W+1)'(WORDS));
    got = sb_q.pop_front();
    chk({tag, "_result"}, {out_cout, out_sum}, got);
    held = {out_cout, out_sum};
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold"}, {out_cout, out_sum}, held);
      chk({tag, "_hold_hs"}, {{W{1'b0}}, out_valid, in_ready, busy}, {{W{1'b0}}, 3'b101});
    end
    out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready_done"}, {{W{1'b0}}, in_ready}, {(W+1){1'b0}});
    step();
    out_ready = 1'b0;
    chk({tag, "_back_idle"}, {{W{1'b0}}, out_valid, in_ready, busy}, {{W{1'b0}}, 3'b010});
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] ra, rb;
    logic         rc, ro;
    logic [W:0]   exp;
    int issued, received, cyc;

    ones      = {W{1'b1}};
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_op     = 1'b0;
    out_ready = 1'b0;

    // Reset state, before any clock edge.
    #2;
    chk("reset_hs", {{W{1'b0}}, in_ready, out_valid, busy}, {{W{1'b0}}, 3'b100});
    chk("reset_out", {out_cout, out_sum}, {(W+1){1'b0}});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // All-ones + 1 wraps to zero with carry out.
    run_op("add_ones", ones, 128'd1, 1'b0, 1'b0, {1'b1, {W{1'b0}}}, 0);
    // Carry rippling across word boundaries.
    run_op("add_interword", 128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0, 1'b0,
           {1'b0, 128'h00000001_00000000_00000000_00000000}, 0);
    // Subtract borrow and exact subtract (cin must be ignored).
    run_op("sub_0_1", 128'd0, 128'd1, 1'b1, 1'b1, {1'b0, ones}, 0);
    run_op("sub_5_5", 128'd5, 128'd5, 1'b0, 1'b1, {1'b1, {W{1'b0}}}, 0);
    // Add with carry-in plus backpressure for 6 cycles.
    run_op("add_bp", 128'h12345678_9ABCDEF0_0FEDCBA9_87654321, 128'h11111111_22222222_33333333_44444444,
           1'b1, 1'b0, {1'b0, 128'h23456789_BCDF0112_4320FEDC_CBA98766}, 6);

    // Reset in the middle of RUN (k=2).
    in_a = 128'd100; in_b = 128'd200; in_cin = 1'b0; in_op = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_hs", {{W{1'b0}}, out_valid, in_ready, busy}, {{W{1'b0}}, 3'b010});
    chk("midrun_reset_out", {out_cout, out_sum}, {(W+1){1'b0}});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("after_reset", 128'd3, 128'd4, 1'b1, 1'b0, {1'b0, 128'd8}, 0);

    // Random back-to-back traffic with random gaps on both sides.
    issued = 0;
    received = 0;
    cyc = 0;
    while ((issued < 200 || received < 200) && cyc < 20000) begin
      ra = rand_word_mix();
      rb = rand_word_mix();
      rc = 1'($urandom_range(0, 1));
      ro = 1'($urandom_range(0, 1));
      in_a = ra; in_b = rb; in_cin = rc; in_op = ro;
      in_valid  = (issued < 200) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (in_valid && in_ready) begin
        sb_q.push_back(ref_model(ra, rb, rc, ro));
        issued++;
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("rand_unexpected", {out_cout, out_sum}, {(W+1){1'bx}});
        end else begin
          exp = sb_q.pop_front();
          chk("rand_result", {out_cout, out_sum}, exp);
        end
        received++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("rand_issued", (W+1)'(issued), (W+1)'(200));
    chk("rand_received", (W+1)'(received), (W+1)'(200));
    chk("rand_sb_empty", (W+1)'(sb_q.size()), (W+1)'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
